// File: rtl/int_exec_cluster.sv
// ----------------------------------------------------------------------------
// int_exec_cluster
// Integer execution cluster: an 8-entry issue queue, a 64-entry physical
// register file and a single-cycle ALU. Renamed uops are dispatched into the
// queue. Their sources wake up on either CDB. The oldest ready uop issues,
// reads the PRF and executes in the same cycle. Its result is broadcast on
// fu_cdb_* one cycle later.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_*                     dispatch interface (valid/ready, uop fields)
//   cdb_in_*                 external result broadcast (wakeup + PRF write)
//   fu_cdb_*                 this unit's registered result broadcast
//
// Configuration macro
//   INT_RS_FAST_WAKEUP_EN    when defined, a CDB match counts as ready in the
//                            same cycle. The operand value is forwarded from
//                            the matching CDB, so a dependent uop issues one
//                            cycle after its producer. When the macro is
//                            undefined, wakeup takes effect at the clock edge
//                            and the operand is read from the PRF.
// ----------------------------------------------------------------------------
module int_exec_cluster #(
    parameter int RS_DEPTH  = 8,
    parameter int PRF_DEPTH = 64,
    parameter int ROB_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    output logic                          id_ready,
    input  logic [31:0]                   id_pc,
    input  logic [3:0]                    id_fu_opcode,
    input  logic [1:0]                    id_op1_sel,
    input  logic                          id_op2_sel,
    input  logic [$clog2(PRF_DEPTH)-1:0]  id_rd_phy,
    input  logic [$clog2(PRF_DEPTH)-1:0]  id_rs1_phy,
    input  logic [$clog2(PRF_DEPTH)-1:0]  id_rs2_phy,
    input  logic                          id_rs1_valid,
    input  logic                          id_rs2_valid,
    input  logic [31:0]                   id_imm,
    input  logic [$clog2(ROB_DEPTH)-1:0]  id_rob_id,
    input  logic [4:0]                    id_rd_arch,
    input  logic                          cdb_in_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0]  cdb_in_rob_id,
    input  logic [$clog2(PRF_DEPTH)-1:0]  cdb_in_rd_phy,
    input  logic [4:0]                    cdb_in_rd_arch,
    input  logic [31:0]                   cdb_in_rd_value,
    output logic                          fu_cdb_valid,
    output logic [$clog2(ROB_DEPTH)-1:0]  fu_cdb_rob_id,
    output logic [$clog2(PRF_DEPTH)-1:0]  fu_cdb_rd_phy,
    output logic [4:0]                    fu_cdb_rd_arch,
    output logic [31:0]                   fu_cdb_rd_value
);
    localparam int PRF_W = $clog2(PRF_DEPTH);
    localparam int ROB_W = $clog2(ROB_DEPTH);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    localparam logic [1:0] OP1_RS1 = 2'd0;
    localparam logic [1:0] OP1_PC  = 2'd1;
    localparam logic       OP2_RS2 = 1'b0;

    typedef struct packed {
        logic [31:0]      pc;
        logic [3:0]       op;
        logic [1:0]       op1_sel;
        logic             op2_sel;
        logic [PRF_W-1:0] rd_phy;
        logic [PRF_W-1:0] rs1_phy;
        logic [PRF_W-1:0] rs2_phy;
        logic             rs1_rdy;
        logic             rs2_rdy;
        logic [31:0]      imm;
        logic [ROB_W-1:0] rob_id;
        logic [4:0]       rd_arch;
    } rs_ent_t;

    function automatic logic cdb_hit(input logic v, input logic [PRF_W-1:0] tag,
                                     input logic [PRF_W-1:0] src);
        return v && (tag == src);
    endfunction

    // Unused sources never block issue.
    function automatic logic ent_ready(input rs_ent_t e);
        return ((e.op1_sel != OP1_RS1) || e.rs1_rdy) && ((e.op2_sel != OP2_RS2) || e.rs2_rdy);
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] res;
        case (op)
            4'd0:    res = a + b;
            4'd1:    res = a - b;
            4'd2:    res = a ^ b;
            4'd3:    res = a | b;
            4'd4:    res = a & b;
            4'd5:    res = {31'd0, ($signed(a) < $signed(b))};
            4'd6:    res = {31'd0, (a < b)};
            4'd7:    res = a << b[4:0];
            4'd8:    res = a >> b[4:0];
            4'd9:    res = $unsigned($signed(a) >>> b[4:0]);
            default: res = 32'd0;
        endcase
        return res;
    endfunction

`ifdef INT_RS_FAST_WAKEUP_EN
    // Same-cycle operand forward; cdb_in has priority, matching the PRF write order.
    function automatic logic [31:0] fwd(input logic [PRF_W-1:0] phy, input logic [31:0] prf_val,
                                        input logic in_v, input logic [PRF_W-1:0] in_tag,
                                        input logic [31:0] in_val, input logic fu_v,
                                        input logic [PRF_W-1:0] fu_tag, input logic [31:0] fu_val);
        return (phy == '0) ? prf_val :
               cdb_hit(in_v, in_tag, phy) ? in_val :
               cdb_hit(fu_v, fu_tag, phy) ? fu_val : prf_val;
    endfunction
`endif

    // Queue is kept compacted: slot 0 is always the oldest entry.
    rs_ent_t           r_ent   [RS_DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_prf   [PRF_DEPTH];
    logic              r_fu_valid;
    logic [ROB_W-1:0]  r_fu_rob_id;
    logic [PRF_W-1:0]  r_fu_rd_phy;
    logic [4:0]        r_fu_rd_arch;
    logic [31:0]       r_fu_rd_value;

    rs_ent_t           w_upd   [RS_DEPTH+1];
    rs_ent_t           w_shift [RS_DEPTH];
    rs_ent_t           w_next  [RS_DEPTH];
    rs_ent_t           w_new;
    rs_ent_t           w_iss;
    logic [RS_DEPTH-1:0] w_ready;
    logic              w_issue;
    logic [IDX_W-1:0]  w_sel;
    logic              w_disp;
    logic [CNT_W-1:0]  w_wr_idx;
    logic [31:0]       w_rs1_val;
    logic [31:0]       w_rs2_val;
    logic [31:0]       w_op1;
    logic [31:0]       w_op2;
    logic [31:0]       w_result;
    logic              w_unused_cdb;

    assign w_unused_cdb = ^{cdb_in_rob_id, cdb_in_rd_arch};

    assign id_ready        = (r_count < CNT_W'(RS_DEPTH));
    assign fu_cdb_valid    = r_fu_valid;
    assign fu_cdb_rob_id   = r_fu_rob_id;
    assign fu_cdb_rd_phy   = r_fu_rd_phy;
    assign fu_cdb_rd_arch  = r_fu_rd_arch;
    assign fu_cdb_rd_value = r_fu_rd_value;

    // Wakeup from both CDBs, readiness per entry and oldest-first select.
    always_comb begin
        w_issue = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_upd[i] = r_ent[i];
            w_upd[i].rs1_rdy = r_ent[i].rs1_rdy
                             | cdb_hit(cdb_in_valid, cdb_in_rd_phy, r_ent[i].rs1_phy)
                             | cdb_hit(r_fu_valid, r_fu_rd_phy, r_ent[i].rs1_phy);
            w_upd[i].rs2_rdy = r_ent[i].rs2_rdy
                             | cdb_hit(cdb_in_valid, cdb_in_rd_phy, r_ent[i].rs2_phy)
                             | cdb_hit(r_fu_valid, r_fu_rd_phy, r_ent[i].rs2_phy);
`ifdef INT_RS_FAST_WAKEUP_EN
            w_ready[i] = ent_ready(w_upd[i]) && (CNT_W'(i) < r_count);
`else
            w_ready[i] = ent_ready(r_ent[i]) && (CNT_W'(i) < r_count);
`endif
        end
        w_upd[RS_DEPTH] = '0;
        // Scanning downward leaves the lowest (oldest) ready slot selected.
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            w_sel   = w_ready[i] ? IDX_W'(i) : w_sel;
            w_issue = w_issue | w_ready[i];
        end
    end

    // Next queue contents: close the gap left by the issuing entry, then append.
    always_comb begin
        w_disp   = id_valid && id_ready;
        w_wr_idx = r_count - CNT_W'(w_issue);
        w_new.pc      = id_pc;
        w_new.op      = id_fu_opcode;
        w_new.op1_sel = id_op1_sel;
        w_new.op2_sel = id_op2_sel;
        w_new.rd_phy  = id_rd_phy;
        w_new.rs1_phy = id_rs1_phy;
        w_new.rs2_phy = id_rs2_phy;
        w_new.rs1_rdy = id_rs1_valid
                      | cdb_hit(cdb_in_valid, cdb_in_rd_phy, id_rs1_phy)
                      | cdb_hit(r_fu_valid, r_fu_rd_phy, id_rs1_phy);
        w_new.rs2_rdy = id_rs2_valid
                      | cdb_hit(cdb_in_valid, cdb_in_rd_phy, id_rs2_phy)
                      | cdb_hit(r_fu_valid, r_fu_rd_phy, id_rs2_phy);
        w_new.imm     = id_imm;
        w_new.rob_id  = id_rob_id;
        w_new.rd_arch = id_rd_arch;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_shift[i] = (w_issue && (IDX_W'(i) >= w_sel)) ? w_upd[i+1] : w_upd[i];
            w_next[i]  = (w_disp && (w_wr_idx == CNT_W'(i))) ? w_new : w_shift[i];
        end
    end

    // Operand fetch and execute for the selected entry.
    always_comb begin
        w_iss = r_ent[w_sel];
`ifdef INT_RS_FAST_WAKEUP_EN
        w_rs1_val = fwd(w_iss.rs1_phy, r_prf[w_iss.rs1_phy], cdb_in_valid, cdb_in_rd_phy,
                        cdb_in_rd_value, r_fu_valid, r_fu_rd_phy, r_fu_rd_value);
        w_rs2_val = fwd(w_iss.rs2_phy, r_prf[w_iss.rs2_phy], cdb_in_valid, cdb_in_rd_phy,
                        cdb_in_rd_value, r_fu_valid, r_fu_rd_phy, r_fu_rd_value);
`else
        w_rs1_val = r_prf[w_iss.rs1_phy];
        w_rs2_val = r_prf[w_iss.rs2_phy];
`endif
        case (w_iss.op1_sel)
            OP1_RS1: w_op1 = w_rs1_val;
            OP1_PC:  w_op1 = w_iss.pc;
            default: w_op1 = 32'd0;
        endcase
        w_op2    = (w_iss.op2_sel == OP2_RS2) ? w_rs2_val : w_iss.imm;
        w_result = alu(w_iss.op, w_op1, w_op2);
    end

    // Queue, result register and PRF state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_fu_valid    <= 1'b0;
            r_fu_rob_id   <= '0;
            r_fu_rd_phy   <= '0;
            r_fu_rd_arch  <= 5'd0;
            r_fu_rd_value <= 32'd0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_ent[i] <= '0;
            end
            for (int i = 0; i < PRF_DEPTH; i++) begin
                r_prf[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_ent[i] <= w_next[i];
            end
            r_count    <= r_count + CNT_W'(w_disp) - CNT_W'(w_issue);
            r_fu_valid <= w_issue;
            if (w_issue) begin
                r_fu_rob_id   <= w_iss.rob_id;
                r_fu_rd_phy   <= w_iss.rd_phy;
                r_fu_rd_arch  <= w_iss.rd_arch;
                r_fu_rd_value <= w_result;
            end
            // cdb_in is written last so it wins a same-phy collision.
            if (r_fu_valid && (r_fu_rd_phy != '0)) begin
                r_prf[r_fu_rd_phy] <= r_fu_rd_value;
            end
            if (cdb_in_valid && (cdb_in_rd_phy != '0)) begin
                r_prf[cdb_in_rd_phy] <= cdb_in_rd_value;
            end
        end
    end

endmodule

// File: tb/tb_int_exec_cluster.sv
module tb_int_exec_cluster;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc;
    logic [3:0]  id_fu_opcode;
    logic [1:0]  id_op1_sel;
    logic        id_op2_sel;
    logic [5:0]  id_rd_phy, id_rs1_phy, id_rs2_phy;
    logic        id_rs1_valid, id_rs2_valid;
    logic [31:0] id_imm;
    logic [4:0]  id_rob_id, id_rd_arch;
    logic        cdb_in_valid;
    logic [4:0]  cdb_in_rob_id, cdb_in_rd_arch;
    logic [5:0]  cdb_in_rd_phy;
    logic [31:0] cdb_in_rd_value;
    logic        fu_cdb_valid;
    logic [4:0]  fu_cdb_rob_id, fu_cdb_rd_arch;
    logic [5:0]  fu_cdb_rd_phy;
    logic [31:0] fu_cdb_rd_value;

`ifdef INT_RS_FAST_WAKEUP_EN
    localparam int WAKE_LAT = 1;
`else
    localparam int WAKE_LAT = 2;
`endif

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd2, OR = 4'd3, AND = 4'd4,
                           SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9;

    typedef struct {
        logic [4:0]  rob;
        logic [5:0]  phy;
        logic [4:0]  arch;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    int_exec_cluster dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_fu_opcode(id_fu_opcode), .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel),
        .id_rd_phy(id_rd_phy), .id_rs1_phy(id_rs1_phy), .id_rs2_phy(id_rs2_phy),
        .id_rs1_valid(id_rs1_valid), .id_rs2_valid(id_rs2_valid), .id_imm(id_imm),
        .id_rob_id(id_rob_id), .id_rd_arch(id_rd_arch),
        .cdb_in_valid(cdb_in_valid), .cdb_in_rob_id(cdb_in_rob_id),
        .cdb_in_rd_phy(cdb_in_rd_phy), .cdb_in_rd_arch(cdb_in_rd_arch),
        .cdb_in_rd_value(cdb_in_rd_value),
        .fu_cdb_valid(fu_cdb_valid), .fu_cdb_rob_id(fu_cdb_rob_id),
        .fu_cdb_rd_phy(fu_cdb_rd_phy), .fu_cdb_rd_arch(fu_cdb_rd_arch),
        .fu_cdb_rd_value(fu_cdb_rd_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every broadcast is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!rst) begin
            if (fu_cdb_valid) begin
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_result: got rob=%0d phy=%0d val=%h at cyc %0d, required no result",
                             fu_cdb_rob_id, fu_cdb_rd_phy, fu_cdb_rd_value, cyc);
                end else begin
                    e = sb.pop_front();
                    if (fu_cdb_rob_id == e.rob && fu_cdb_rd_phy == e.phy && fu_cdb_rd_arch == e.arch &&
                        fu_cdb_rd_value == e.val && cyc == e.cyc) begin
                        n_pass++;
                    end else begin
                        $display("FAIL result_rob%0d: got rob=%0d phy=%0d arch=%0d val=%h cyc=%0d, required rob=%0d phy=%0d arch=%0d val=%h cyc=%0d",
                                 e.rob, fu_cdb_rob_id, fu_cdb_rd_phy, fu_cdb_rd_arch, fu_cdb_rd_value, cyc,
                                 e.rob, e.phy, e.arch, e.val, e.cyc);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                n_chk++;
                e = sb.pop_front();
                $display("FAIL missing_rob%0d: got no result at cyc %0d, required val=%h", e.rob, cyc, e.val);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    task automatic push(input logic [4:0] rob, input logic [5:0] phy, input logic [31:0] val, input int c);
        exp_t x;
        x.rob = rob; x.phy = phy; x.arch = phy[4:0]; x.val = val; x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic disp(input logic [3:0] op, input logic [1:0] s1, input logic s2,
                        input logic [5:0] rd, input logic [5:0] rs1, input logic [5:0] rs2,
                        input logic v1, input logic v2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rob);
        id_fu_opcode = op; id_op1_sel = s1; id_op2_sel = s2;
        id_rd_phy = rd; id_rs1_phy = rs1; id_rs2_phy = rs2;
        id_rs1_valid = v1; id_rs2_valid = v2; id_imm = imm; id_pc = pc;
        id_rob_id = rob; id_rd_arch = rd[4:0]; id_valid = 1'b1;
        @(posedge clk); #1;
        id_valid = 1'b0;
    endtask

    // Dispatch a uop whose sources are ready: it issues the cycle after capture.
    task automatic go(input logic [3:0] op, input logic [1:0] s1, input logic s2,
                      input logic [5:0] rd, input logic [5:0] rs1, input logic [5:0] rs2,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rob,
                      input logic [31:0] val);
        push(rob, rd, val, cyc + 2);
        disp(op, s1, s2, rd, rs1, rs2, 1'b1, 1'b1, imm, pc, rob);
    endtask

    task automatic cdb(input logic [5:0] phy, input logic [31:0] val);
        cdb_in_valid = 1'b1; cdb_in_rd_phy = phy; cdb_in_rd_value = val;
        cdb_in_rd_arch = phy[4:0]; cdb_in_rob_id = 5'd31;
        @(posedge clk); #1;
        cdb_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        logic [5:0] src;
        rst = 1'b1; id_valid = 1'b0; id_pc = 32'd0; id_fu_opcode = 4'd0; id_op1_sel = 2'd0;
        id_op2_sel = 1'b0; id_rd_phy = 6'd0; id_rs1_phy = 6'd0; id_rs2_phy = 6'd0;
        id_rs1_valid = 1'b0; id_rs2_valid = 1'b0; id_imm = 32'd0; id_rob_id = 5'd0;
        id_rd_arch = 5'd0; cdb_in_valid = 1'b0; cdb_in_rob_id = 5'd0; cdb_in_rd_phy = 6'd0;
        cdb_in_rd_arch = 5'd0; cdb_in_rd_value = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_id_ready", {31'd0, id_ready}, 32'd1);
        chk("reset_fu_valid", {31'd0, fu_cdb_valid}, 32'd0);

        // Single ADD p1 = p2 + 1.
        go(ADD, 2'd0, 1'b1, 6'd1, 6'd2, 6'd0, 32'd1, 32'd0, 5'd0, 32'd1);
        drain();

        // Ten back-to-back independent uops.
        go(ADD,  2'd0, 1'b1, 6'd1,  6'd2,  6'd0, 32'd1,         32'd0, 5'd0, 32'd1);
        go(XOR,  2'd0, 1'b0, 6'd3,  6'd4,  6'd4, 32'd0,         32'd0, 5'd1, 32'd0);
        go(OR,   2'd0, 1'b1, 6'd5,  6'd6,  6'd0, 32'hFFFFFFFF,  32'd0, 5'd2, 32'hFFFFFFFF);
        go(AND,  2'd0, 1'b1, 6'd7,  6'd8,  6'd0, 32'hFFFFFFFF,  32'd0, 5'd3, 32'd0);
        go(SUB,  2'd0, 1'b1, 6'd9,  6'd10, 6'd0, 32'd1,         32'd0, 5'd4, 32'hFFFFFFFF);
        go(SLTU, 2'd0, 1'b1, 6'd11, 6'd12, 6'd0, 32'd1,         32'd0, 5'd5, 32'd1);
        go(SLT,  2'd0, 1'b1, 6'd13, 6'd14, 6'd0, 32'hFFFFFFFF,  32'd0, 5'd6, 32'd0);
        go(SLL,  2'd0, 1'b1, 6'd15, 6'd1,  6'd0, 32'd33,        32'd0, 5'd7, 32'd2);
        go(SRL,  2'd0, 1'b1, 6'd16, 6'd5,  6'd0, 32'd1,         32'd0, 5'd8, 32'h7FFFFFFF);
        go(SRA,  2'd0, 1'b1, 6'd17, 6'd5,  6'd0, 32'd1,         32'd0, 5'd9, 32'hFFFFFFFF);
        drain();

        // Dependency on p20, woken by cdb_in.
        disp(ADD, 2'd0, 1'b1, 6'd21, 6'd20, 6'd0, 1'b0, 1'b0, 32'd3, 32'd0, 5'd10);
        @(posedge clk); #1;
        push(5'd10, 6'd21, 32'd8, cyc + WAKE_LAT);
        cdb(6'd20, 32'd5);
        drain();

        // Fill with eight waiting uops; slots 1 and 2 share source p31.
        for (int k = 0; k < 8; k++) begin
            src = (k == 2) ? 6'd31 : 6'(30 + k);
            disp(ADD, 2'd0, 1'b1, 6'(40 + k), src, 6'd0, 1'b0, 1'b0, 32'(k), 32'd0, 5'(11 + k));
        end
        chk("full_id_ready", {31'd0, id_ready}, 32'd0);
        c0 = cyc;
        push(5'd11, 6'd40, 32'd100, c0 + WAKE_LAT);
        cdb(6'd30, 32'd100);
        repeat (WAKE_LAT - 1) begin
            @(posedge clk); #1;
        end
        chk("id_ready_after_issue", {31'd0, id_ready}, 32'd1);
        drain();

        // Two entries ready together: older first.
        c0 = cyc;
        push(5'd12, 6'd41, 32'd201, c0 + WAKE_LAT);
        push(5'd13, 6'd42, 32'd202, c0 + WAKE_LAT + 1);
        cdb(6'd31, 32'd200);
        drain();
        push(5'd14, 6'd43, 32'd10, cyc + WAKE_LAT);
        cdb(6'd33, 32'd7);
        drain();
        push(5'd15, 6'd44, 32'd13, cyc + WAKE_LAT);
        cdb(6'd34, 32'd9);
        drain();

        // Reset with three entries queued; their wakeups must produce nothing.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("post_reset_id_ready", {31'd0, id_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("post_reset_no_result", {31'd0, fu_cdb_valid}, 32'd0);
            if (k < 3) cdb(6'(35 + k), 32'd77);
            else begin
                @(posedge clk); #1;
            end
        end

        // PRF cleared, PC and ZERO operand selects, p0 write ignored.
        go(ADD, 2'd0, 1'b1, 6'd50, 6'd1, 6'd0, 32'd0, 32'd0,      5'd20, 32'd0);
        go(ADD, 2'd1, 1'b1, 6'd51, 6'd0, 6'd0, 32'd4, 32'h1000,   5'd21, 32'h1004);
        go(SUB, 2'd2, 1'b1, 6'd52, 6'd0, 6'd0, 32'd1, 32'd0,      5'd22, 32'hFFFFFFFF);
        go(ADD, 2'd2, 1'b1, 6'd0,  6'd0, 6'd0, 32'd5, 32'd0,      5'd23, 32'd5);
        drain();
        go(ADD, 2'd0, 1'b1, 6'd53, 6'd0, 6'd0, 32'd0, 32'd0,      5'd24, 32'd0);
        drain();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
